// File: rtl/writeback_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage_pkg
// Description : Shared encodings for the MIPS writeback stage:
//               load-size codes, writeback FSM states and a write-enable
//               helper used by the top level.
// Revision    : 1.0 - initial release
// ============================================================================
package writeback_stage_pkg;

    // Load-size encodings carried on i_load_size (2'b11 is reserved and
    // behaves like a word load).
    localparam logic [1:0] LOAD_BYTE = 2'b00;
    localparam logic [1:0] LOAD_HALF = 2'b01;
    localparam logic [1:0] LOAD_WORD = 2'b10;

    // Program-halt state machine encoding.
    typedef enum logic [0:0] {
        WB_RUN    = 1'b0,
        WB_HALTED = 1'b1
    } wb_state_t;

    // A register write is committed only for a real instruction that asks
    // for it, does not target r0 and is not the HALT instruction itself.
    function automatic logic wb_write_enable(
        input logic reg_write,
        input logic instr_valid,
        input logic dst_nonzero,
        input logic halt
    );
        return reg_write & instr_valid & dst_nonzero & ~halt;
    endfunction

endpackage : writeback_stage_pkg
`default_nettype wire

// File: rtl/writeback_load_align.sv
`default_nettype none
// ============================================================================
// Module      : writeback_load_align
// Description : Combinational load-data alignment. Selects the addressed
//               byte or halfword lane of a little-endian memory word and
//               sign- or zero-extends it to NB_DATA bits.
// Ports       : i_mem_data      - full word read from data memory
//               i_offset        - byte offset within the word (addr[1:0])
//               i_load_size     - LOAD_BYTE / LOAD_HALF / LOAD_WORD
//               i_load_unsigned - 1 = zero-extend, 0 = sign-extend
//               o_load_data     - aligned, extended load value
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_load_align
    import writeback_stage_pkg::*;
#(
    parameter int NB_DATA = 32
) (
    input  logic [NB_DATA-1:0] i_mem_data,
    input  logic [1:0]         i_offset,
    input  logic [1:0]         i_load_size,
    input  logic               i_load_unsigned,
    output logic [NB_DATA-1:0] o_load_data
);

    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic               w_byte_fill;
    logic               w_half_fill;
    logic [NB_DATA-1:0] w_byte_ext;
    logic [NB_DATA-1:0] w_half_ext;

    // Little-endian lane selection: offset 0 is the least significant lane.
    always_comb begin
        w_byte = i_mem_data[7:0];
        case (i_offset)
            2'd0:    w_byte = i_mem_data[7:0];
            2'd1:    w_byte = i_mem_data[15:8];
            2'd2:    w_byte = i_mem_data[23:16];
            default: w_byte = i_mem_data[31:24];
        endcase
        // Halfword lane follows offset bit 1 only; bit 0 is ignored.
        w_half = i_offset[1] ? i_mem_data[31:16] : i_mem_data[15:0];
    end

    assign w_byte_fill = ~i_load_unsigned & w_byte[7];
    assign w_half_fill = ~i_load_unsigned & w_half[15];
    assign w_byte_ext  = {{(NB_DATA-8){w_byte_fill}}, w_byte};
    assign w_half_ext  = {{(NB_DATA-16){w_half_fill}}, w_half};

    always_comb begin
        o_load_data = i_mem_data;
        case (i_load_size)
            LOAD_BYTE: o_load_data = w_byte_ext;
            LOAD_HALF: o_load_data = w_half_ext;
            default:   o_load_data = i_mem_data;
        endcase
    end

endmodule : writeback_load_align
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : writeback_stage
// Description : Final MIPS pipeline stage. Selects and registers the value
//               written back to the register file (ALU result, aligned load
//               data or link address), owns the program-halt FSM and counts
//               retired instructions for the debug unit.
// Ports       : i_clock / i_reset       - clock, async active-low reset
//               i_valid                 - global step enable
//               i_instr_valid           - real instruction (0 = bubble)
//               i_alu_result            - ALU result, [1:0] = load offset
//               i_mem_data              - data-memory read word
//               i_pc_next               - link value (PC+1)
//               i_reg_dst               - destination register index
//               i_reg_write, i_mem_to_reg, i_link - write-back controls
//               i_load_size, i_load_unsigned      - load format
//               i_halt                  - HALT instruction in writeback
//               o_data_reg_write        - register-file write data
//               o_data_reg_write_sel    - register-file write index
//               o_write_reg_enable      - register-file write strobe
//               o_halt                  - program halted
//               o_retired_count         - instructions retired since reset
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int NB_DATA     = 32,
    parameter int NB_REGISTER = 5,
    parameter int NB_COUNT    = 32
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic                   i_instr_valid,
    input  logic [NB_DATA-1:0]     i_alu_result,
    input  logic [NB_DATA-1:0]     i_mem_data,
    input  logic [NB_DATA-1:0]     i_pc_next,
    input  logic [NB_REGISTER-1:0] i_reg_dst,
    input  logic                   i_reg_write,
    input  logic                   i_mem_to_reg,
    input  logic                   i_link,
    input  logic [1:0]             i_load_size,
    input  logic                   i_load_unsigned,
    input  logic                   i_halt,
    output logic [NB_DATA-1:0]     o_data_reg_write,
    output logic [NB_REGISTER-1:0] o_data_reg_write_sel,
    output logic                   o_write_reg_enable,
    output logic                   o_halt,
    output logic [NB_COUNT-1:0]    o_retired_count
);

    localparam logic [NB_COUNT-1:0] c_count_one = {{(NB_COUNT-1){1'b0}}, 1'b1};

    wb_state_t              r_state;
    logic [NB_DATA-1:0]     r_data;
    logic [NB_REGISTER-1:0] r_sel;
    logic                   r_we;
    logic                   r_halt;
    logic [NB_COUNT-1:0]    r_count;

    logic [NB_DATA-1:0]     w_load_data;
    logic [NB_DATA-1:0]     w_write_data;
    logic                   w_we;

    writeback_load_align #(
        .NB_DATA (NB_DATA)
    ) u_load_align (
        .i_mem_data      (i_mem_data),
        .i_offset        (i_alu_result[1:0]),
        .i_load_size     (i_load_size),
        .i_load_unsigned (i_load_unsigned),
        .o_load_data     (w_load_data)
    );

    // Link has priority over memory, memory over the ALU result.
    always_comb begin
        w_write_data = i_alu_result;
        if (i_link) begin
            w_write_data = i_pc_next;
        end else if (i_mem_to_reg) begin
            w_write_data = w_load_data;
        end
    end

    assign w_we = wb_write_enable(i_reg_write, i_instr_valid, |i_reg_dst, i_halt);

    // FSM, output registers and retired counter. Nothing moves while
    // i_valid is low; once halted only reset brings the stage back.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= WB_RUN;
            r_data  <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_halt  <= 1'b0;
            r_count <= '0;
        end else if (i_valid) begin
            case (r_state)
                WB_RUN: begin
                    r_data <= w_write_data;
                    r_sel  <= i_reg_dst;
                    r_we   <= w_we;
                    if (i_instr_valid) begin
                        r_count <= r_count + c_count_one;
                        // The halt instruction itself retires but writes nothing.
                        if (i_halt) begin
                            r_state <= WB_HALTED;
                            r_halt  <= 1'b1;
                        end
                    end
                end
                WB_HALTED: begin
                    r_we   <= 1'b0;
                    r_halt <= 1'b1;
                end
                default: begin
                    r_state <= WB_RUN;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    assign o_data_reg_write     = r_data;
    assign o_data_reg_write_sel = r_sel;
    assign o_write_reg_enable   = r_we;
    assign o_halt               = r_halt;
    assign o_retired_count      = r_count;

endmodule : writeback_stage
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_stage
// Description : Scoreboard testbench for writeback_stage. A reference model
//               of the stage's observable behaviour predicts the outputs for
//               each clock edge; a negedge monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

    logic        clk;
    logic        rst_n;
    logic        valid;
    logic        instr_valid;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [31:0] pc_next;
    logic [4:0]  reg_dst;
    logic        reg_write;
    logic        mem_to_reg;
    logic        link;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic        halt;
    logic [31:0] data_out;
    logic [4:0]  sel_out;
    logic        we_out;
    logic        halt_out;
    logic [31:0] count_out;

    writeback_stage #(
        .NB_DATA     (32),
        .NB_REGISTER (5),
        .NB_COUNT    (32)
    ) dut (
        .i_clock              (clk),
        .i_reset              (rst_n),
        .i_valid              (valid),
        .i_instr_valid        (instr_valid),
        .i_alu_result         (alu_result),
        .i_mem_data           (mem_data),
        .i_pc_next            (pc_next),
        .i_reg_dst            (reg_dst),
        .i_reg_write          (reg_write),
        .i_mem_to_reg         (mem_to_reg),
        .i_link               (link),
        .i_load_size          (load_size),
        .i_load_unsigned      (load_unsigned),
        .i_halt               (halt),
        .o_data_reg_write     (data_out),
        .o_data_reg_write_sel (sel_out),
        .o_write_reg_enable   (we_out),
        .o_halt               (halt_out),
        .o_retired_count      (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  sel;
        logic        we;
        logic        hlt;
        logic [31:0] count;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state
    logic [31:0] m_data;
    logic [4:0]  m_sel;
    logic        m_we;
    logic        m_halted;
    logic [31:0] m_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Load value from the architectural rules: shift the lane down, mask,
    // then sign-extend arithmetically by flipping and subtracting the sign bit.
    function automatic logic [31:0] ref_load(input logic [31:0] mem, input logic [1:0] off,
                                             input logic [1:0] sz, input logic uns);
        logic [31:0] b;
        logic [31:0] h;
        b = (mem >> (8 * int'(off))) & 32'h0000_00FF;
        h = (mem >> (16 * int'(off[1]))) & 32'h0000_FFFF;
        if (sz == 2'd0) return uns ? b : (b ^ 32'h80) - 32'h80;
        if (sz == 2'd1) return uns ? h : (h ^ 32'h8000) - 32'h8000;
        return mem;
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.data  = m_data;
        e.sel   = m_sel;
        e.we    = m_we;
        e.hlt   = m_halted;
        e.count = m_count;
        return e;
    endfunction

    task automatic model_reset();
        m_data = '0; m_sel = '0; m_we = 1'b0; m_halted = 1'b0; m_count = '0;
    endtask

    task automatic model_step();
        if (!valid || m_halted) return;
        if (link)            m_data = pc_next;
        else if (mem_to_reg) m_data = ref_load(mem_data, alu_result[1:0], load_size, load_unsigned);
        else                 m_data = alu_result;
        m_sel = reg_dst;
        m_we  = reg_write && instr_valid && (reg_dst != 5'd0) && !halt;
        if (instr_valid) begin
            m_count = m_count + 32'd1;
            if (halt) m_halted = 1'b1;
        end
    endtask

    // Monitor: outputs are stable at the negedge following the capturing edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("data",  data_out,          e.data);
            chk("sel",   {27'd0, sel_out},  {27'd0, e.sel});
            chk("we",    {31'd0, we_out},   {31'd0, e.we});
            chk("halt",  {31'd0, halt_out}, {31'd0, e.hlt});
            chk("count", count_out,         e.count);
        end
    end

    // Drive one cycle of stimulus (called at negedge+1), predict, wait.
    task automatic step(input logic v, input logic iv, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [31:0] pc, input logic [4:0] dst,
                        input logic rw, input logic m2r, input logic lnk,
                        input logic [1:0] sz, input logic uns, input logic hlt);
        valid = v; instr_valid = iv; alu_result = alu; mem_data = mem; pc_next = pc;
        reg_dst = dst; reg_write = rw; mem_to_reg = m2r; link = lnk;
        load_size = sz; load_unsigned = uns; halt = hlt;
        model_step();
        sb.push_back(snapshot());
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic rand_step(input logic allow_halt);
        logic v, iv;
        logic [4:0] dst;
        v   = ($urandom_range(0, 3) != 0);
        iv  = ($urandom_range(0, 4) != 0);
        dst = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        step(v, iv, $urandom, $urandom, $urandom, dst, 1'($urandom), 1'($urandom),
             ($urandom_range(0, 5) == 0), 2'($urandom), 1'($urandom),
             allow_halt & 1'($urandom));
    endtask

    // Async reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_data",  data_out,            32'd0);
        chk("rst_sel",   {27'd0, sel_out},    32'd0);
        chk("rst_we",    {31'd0, we_out},     32'd0);
        chk("rst_halt",  {31'd0, halt_out},   32'd0);
        chk("rst_count", count_out,           32'd0);
        for (int i = 0; i < cycles; i++) begin
            valid = 1'b1; instr_valid = 1'b1; reg_write = 1'b1; reg_dst = 5'd3;
            sb.push_back(snapshot());
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    localparam logic [31:0] c_mem = 32'h80FF_7F01;

    initial begin
        valid = 1'b0; instr_valid = 1'b0; alu_result = '0; mem_data = '0; pc_next = '0;
        reg_dst = '0; reg_write = 1'b0; mem_to_reg = 1'b0; link = 1'b0;
        load_size = '0; load_unsigned = 1'b0; halt = 1'b0; rst_n = 1'b0;
        model_reset();
        do_reset(2);

        // ALU write
        step(1, 1, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 1, 0, 0, 2'd2, 0, 0);
        // Loads from a fixed word
        step(1, 1, 32'h0000_0102, c_mem, 32'h0, 5'd6, 1, 1, 0, 2'd0, 0, 0); // LB  off2
        step(1, 1, 32'h0000_0103, c_mem, 32'h0, 5'd7, 1, 1, 0, 2'd0, 1, 0); // LBU off3
        step(1, 1, 32'h0000_0202, c_mem, 32'h0, 5'd8, 1, 1, 0, 2'd1, 0, 0); // LH  off2
        step(1, 1, 32'h0000_0200, c_mem, 32'h0, 5'd9, 1, 1, 0, 2'd1, 1, 0); // LHU off0
        step(1, 1, 32'h0000_0303, c_mem, 32'h0, 5'd10, 1, 1, 0, 2'd2, 0, 0); // LW
        step(1, 1, 32'h0000_0301, c_mem, 32'h0, 5'd11, 1, 1, 0, 2'd3, 0, 0); // reserved
        // Link (beats mem_to_reg), then r0 suppression
        step(1, 1, 32'h0000_0001, c_mem, 32'h40, 5'd31, 1, 1, 1, 2'd0, 0, 0);
        step(1, 1, 32'hDEAD_BEEF, c_mem, 32'h44, 5'd0, 1, 0, 0, 2'd2, 0, 0);
        // Stall then bubble
        for (int i = 0; i < 3; i++)
            step(0, 1, $urandom, $urandom, $urandom, 5'd12, 1, 0, 0, 2'd2, 0, 1);
        step(1, 0, 32'h5555_0000, c_mem, 32'h48, 5'd13, 1, 0, 0, 2'd2, 0, 0);

        for (int i = 0; i < 300; i++) rand_step(1'b0);
        // Mid-stream reset
        do_reset(1);
        for (int i = 0; i < 200; i++) rand_step(1'b0);

        // Halt while also asking for a write, then inputs are ignored
        step(1, 1, 32'h0000_0777, c_mem, 32'h80, 5'd14, 1, 0, 0, 2'd2, 0, 1);
        for (int i = 0; i < 40; i++) rand_step(1'b1);
        step(1, 1, 32'h0000_0999, c_mem, 32'h84, 5'd15, 1, 0, 0, 2'd2, 0, 0);

        // Reset releases the halt and the stage runs again
        do_reset(1);
        step(1, 1, 32'hCAFE_0001, c_mem, 32'h0, 5'd16, 1, 0, 0, 2'd2, 0, 0);
        for (int i = 0; i < 100; i++) rand_step(1'b1);

        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_writeback_stage
`default_nettype wire

// File: doc/writeback_stage.md
# writeback_stage

Final MIPS pipeline stage. Registers the memory-stage results and selects the value to write back: ALU result, aligned/extended load data, or link address. Drives the register-file write port of the decode stage (write data, write select, write enable). Also owns the program-halt state machine and a retired-instruction counter for the debug unit.

## Interface
Parameters:
- NB_DATA, 32, datapath width
- NB_REGISTER, 5, register index width
- NB_COUNT, 32, retired-instruction counter width

Ports:
- i_clock  in  1  clock; all state updates on posedge
- i_reset  in  1  asynchronous, active-low reset
- i_valid  in  1  global step enable; state and outputs update only when high
- i_instr_valid  in  1  1 = real instruction, 0 = bubble/flushed slot
- i_alu_result  in  NB_DATA  ALU result; bits [1:0] are the load byte offset
- i_mem_data  in  NB_DATA  full word read from data memory
- i_pc_next  in  NB_DATA  PC+1 of the instruction (link value)
- i_reg_dst  in  NB_REGISTER  destination register index
- i_reg_write  in  1  instruction writes a register
- i_mem_to_reg  in  1  write data comes from memory
- i_link  in  1  JAL/JALR: write data is i_pc_next
- i_load_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- i_load_unsigned  in  1  zero-extend (LBU/LHU) instead of sign-extend
- i_halt  in  1  HALT instruction reached writeback
- o_data_reg_write  out  NB_DATA  register-file write data
- o_data_reg_write_sel  out  NB_REGISTER  register-file write index
- o_write_reg_enable  out  1  register-file write strobe
- o_halt  out  1  program halted
- o_retired_count  out  NB_COUNT  instructions retired since reset

## Operation
- FSM states: RUN, HALTED. Reset -> RUN.
- RUN, i_valid=1: capture the inputs, compute the outputs (rules below), register them.
- RUN, i_valid=1, i_instr_valid=1, i_halt=1 -> HALTED. The halt instruction itself writes nothing and counts as retired.
- HALTED: ignore all inputs; o_write_reg_enable=0; o_halt=1. Leave only via reset.
- i_valid=0 (either state): every output and all state hold their values.
- Write-data priority:
  - i_link -> i_pc_next.
  - else i_mem_to_reg -> extracted load.
  - else i_alu_result.
- Load extraction (little-endian, off = i_alu_result[1:0]):
  - byte: lane off (off=0 -> bits 7:0).
  - half: lane off[1] (off[1]=0 -> bits 15:0); off[0] ignored.
  - word: unchanged.
  - Extend to NB_DATA: sign-extend, or zero-extend when i_load_unsigned=1.
- o_write_reg_enable = i_reg_write & i_instr_valid & (i_reg_dst != 0) & ~i_halt. Writes to r0 are suppressed.
- o_retired_count increments by 1 per accepted cycle with i_instr_valid=1 in RUN. Wraps modulo 2^NB_COUNT.

## Timing
- Latency: one cycle. Inputs sampled on posedge with i_valid=1 appear on outputs after that edge.
- All outputs registered; none combinational from inputs.
- Reset values: o_data_reg_write=0, o_data_reg_write_sel=0, o_write_reg_enable=0, o_halt=0, o_retired_count=0.
- Reset asserted mid-operation clears everything immediately, regardless of clock or i_valid.
- The decode stage latches write data on negedge. Outputs are therefore stable for a full half-cycle before use.
- Halt on the edge that sees i_halt: o_halt=1 and o_write_reg_enable=0 after that same edge.

## Structure
- Shared package holds:
  - load-size encodings LOAD_BYTE=2'b00, LOAD_HALF=2'b01, LOAD_WORD=2'b10
  - FSM state encoding WB_RUN, WB_HALTED
- One sub-module: writeback_load_align. Combinational lane select plus sign/zero extension, parameterised by NB_DATA.
- Top level holds the FSM, the output registers and the counter.

## Test plan
- Reset: drive i_reset=0 mid-stream -> all outputs 0 immediately; FSM in RUN after release.
- ALU write: alu=0x0000_1234, dst=5, reg_write=1 -> next edge: data=0x0000_1234, sel=5, we=1, count=1.
- Loads from mem=0x80FF_7F01:
  - LB off=2 -> 0xFFFF_FFFF.
  - LBU off=3 -> 0x0000_0080.
  - LH off=2 -> 0xFFFF_80FF.
  - LHU off=0 -> 0x0000_7F01.
  - LW -> 0x80FF_7F01.
- Link and r0: link=1, pc_next=0x40, dst=31 -> data=0x40, we=1. Then reg_write=1, dst=0 -> we=0.
- Stall and bubble: i_valid=0 for 3 cycles -> outputs frozen and count unchanged. Then i_instr_valid=0 -> we=0 and count unchanged.
- Halt: i_halt=1 with reg_write=1 -> o_halt=1, we=0, count+1. Later valid writes are ignored and count is frozen.
